// File: rtl/data_memory_responder.sv
// Block-granular data memory answering cache line fills and write-backs
// after a fixed, parameterised latency, with a busy-wait stall handshake.
`timescale 1ns/1ps

module data_memory_responder #(
    parameter int BLOCK_ADDR_WIDTH = 6,
    parameter int LATENCY          = 5
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         MEM_READ,
    input  logic         MEM_WRITE,
    input  logic [27:0]  MEM_ADDRESS,
    input  logic [127:0] MEM_WRITEDATA,
    output logic [127:0] MEM_READDATA,
    output logic         MEM_BUSYWAIT
);

    localparam int         DEPTH        = 2 ** BLOCK_ADDR_WIDTH;
    localparam logic [7:0] LATENCY_LOAD = 8'(LATENCY);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t                      state;
    state_t                      state_next;
    logic [7:0]                  count;
    logic                        op_write;
    logic [BLOCK_ADDR_WIDTH-1:0] addr_q;
    logic [127:0]                wdata_q;
    logic [127:0]                mem [DEPTH];
    logic                        request;
    logic                        last_cycle;

    assign request    = MEM_READ | MEM_WRITE;
    assign last_cycle = (state == BUSY) && (count == 8'd1);

    // Address bits above the decoded range alias onto the same lines.
    if (BLOCK_ADDR_WIDTH < 28) begin : g_addr_alias
        logic unused_addr_bits;
        assign unused_addr_bits = ^MEM_ADDRESS[27:BLOCK_ADDR_WIDTH];
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        MEM_BUSYWAIT = 1'b0;
        case (state)
            IDLE: begin
                MEM_BUSYWAIT = request;
                if (request) begin
                    state_next = BUSY;
                end
            end
            BUSY: begin
                MEM_BUSYWAIT = 1'b1;
                if (count == 8'd1) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        // The IDLE stall is combinational, so it must be masked while in reset.
        if (!RESET) begin
            MEM_BUSYWAIT = 1'b0;
        end
    end

    // A request arriving with both strobes high is serviced as a write.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            count        <= '0;
            op_write     <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            MEM_READDATA <= '0;
        end else begin
            if (state == IDLE && request) begin
                op_write <= MEM_WRITE;
                addr_q   <= MEM_ADDRESS[BLOCK_ADDR_WIDTH-1:0];
                wdata_q  <= MEM_WRITEDATA;
                count    <= LATENCY_LOAD;
            end else if (state == BUSY && count != 8'd1) begin
                count <= count - 8'd1;
            end
            if (last_cycle && !op_write) begin
                MEM_READDATA <= mem[addr_q];
            end
        end
    end

    // NOTE: the array is cleared by reset, which rules out RAM-macro inference;
    // the block relies on every line reading 0 after reset.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (last_cycle && op_write) begin
            mem[addr_q] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_data_memory_responder.sv
// Scoreboard bench for data_memory_responder: one instance at LATENCY=5 and
// one at LATENCY=1, each completed access checked by a negedge monitor.
`timescale 1ns/1ps

module tb_data_memory_responder;

    logic         CLK = 1'b0;
    logic         RESET;
    logic         rd    [2];
    logic         wr    [2];
    logic [27:0]  addr  [2];
    logic [127:0] wdata [2];
    logic [127:0] rdata [2];
    logic         busy  [2];

    always #5 CLK = ~CLK;

    data_memory_responder #(.BLOCK_ADDR_WIDTH(6), .LATENCY(5)) dut (
        .CLK(CLK), .RESET(RESET),
        .MEM_READ(rd[0]), .MEM_WRITE(wr[0]), .MEM_ADDRESS(addr[0]),
        .MEM_WRITEDATA(wdata[0]), .MEM_READDATA(rdata[0]), .MEM_BUSYWAIT(busy[0])
    );

    data_memory_responder #(.BLOCK_ADDR_WIDTH(6), .LATENCY(1)) dut_l1 (
        .CLK(CLK), .RESET(RESET),
        .MEM_READ(rd[1]), .MEM_WRITE(wr[1]), .MEM_ADDRESS(addr[1]),
        .MEM_WRITEDATA(wdata[1]), .MEM_READDATA(rdata[1]), .MEM_BUSYWAIT(busy[1])
    );

    typedef struct {
        int           d;
        logic [127:0] rdata;
        int           busy_len;
        string        name;
    } exp_t;

    exp_t         sb_q [$];
    logic [127:0] last_read [2];
    int           tests_run    = 0;
    int           tests_failed = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        tests_run++;
        tests_failed++;
        $display("FAIL %s", name);
    endtask

    // Monitor: a busy->not-busy transition outside reset marks the DONE cycle.
    bit prev_busy [2];
    int busy_len  [2];
    always @(negedge CLK) begin
        exp_t e;
        for (int d = 0; d < 2; d++) begin
            if (!RESET) begin
                prev_busy[d] = 1'b0;
                busy_len[d]  = 0;
            end else if (busy[d]) begin
                prev_busy[d] = 1'b1;
                busy_len[d]++;
            end else if (prev_busy[d]) begin
                if (sb_q.size() == 0 || sb_q[0].d != d) begin
                    fail_now($sformatf("unexpected_done dut%0d", d));
                end else begin
                    e = sb_q.pop_front();
                    check({e.name, "_readdata"}, rdata[d], e.rdata);
                    check({e.name, "_busy_len"}, 128'(busy_len[d]), 128'(e.busy_len));
                end
                prev_busy[d] = 1'b0;
                busy_len[d]  = 0;
            end
        end
    end

    // Issue one request, hold it until the DONE cycle, then drop it.
    task automatic access(input int d, input bit r, input bit w, input logic [27:0] a,
                          input logic [127:0] wd, input logic [127:0] rexp,
                          input string name, input bit perturb);
        exp_t e;
        int   n;
        @(posedge CLK);
        #1;
        rd[d]    = r;
        wr[d]    = w;
        addr[d]  = a;
        wdata[d] = wd;
        if (r && !w) last_read[d] = rexp;
        e.d        = d;
        e.rdata    = last_read[d];
        e.busy_len = (d == 0) ? 6 : 2;
        e.name     = name;
        sb_q.push_back(e);
        n = 0;
        @(negedge CLK);
        while (busy[d] && n < 300) begin
            if (perturb && n == 2) begin
                addr[d]  = 28'h000000B;
                wdata[d] = {4{32'hDEADBEEF}};
            end
            @(negedge CLK);
            n++;
        end
        rd[d] = 1'b0;
        wr[d] = 1'b0;
        if (n >= 300) fail_now({name, "_timeout"});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] line_w;
        logic [127:0] line_a;
        line_w = 128'h44444444_33333333_22222222_11111111;
        line_a = {32{4'hA}};
        RESET  = 1'b0;
        for (int d = 0; d < 2; d++) begin
            rd[d]        = 1'b0;
            wr[d]        = 1'b0;
            addr[d]      = '0;
            wdata[d]     = '0;
            last_read[d] = '0;
        end

        // 1: reset, idle, read of a never-written block
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("reset_busy dut%0d", d), 128'(busy[d]), 128'(0));
            check($sformatf("reset_readdata dut%0d", d), rdata[d], 128'(0));
        end
        @(posedge CLK);
        #1 RESET = 1'b1;
        repeat (4) begin
            @(negedge CLK);
            for (int d = 0; d < 2; d++) begin
                check($sformatf("idle_busy dut%0d", d), 128'(busy[d]), 128'(0));
                check($sformatf("idle_readdata dut%0d", d), rdata[d], 128'(0));
            end
        end
        access(0, 1'b1, 1'b0, 28'h0000005, '0, 128'h0, "t1_read_05", 1'b0);

        // 2: write then read back
        access(0, 1'b0, 1'b1, 28'h0000003, line_w, '0, "t2_write_03", 1'b0);
        access(0, 1'b1, 1'b0, 28'h0000003, '0, line_w, "t2_read_03", 1'b0);

        // 3: inputs changed during BUSY are ignored
        access(0, 1'b0, 1'b1, 28'h000000A, line_a, '0, "t3_write_0a", 1'b0);
        access(0, 1'b1, 1'b0, 28'h000000A, '0, line_a, "t3_read_0a", 1'b1);

        // 4: simultaneous read+write is a write; readdata keeps A..A
        access(0, 1'b1, 1'b1, 28'h0000007, 128'h1234, '0, "t4_both", 1'b0);
        access(0, 1'b1, 1'b0, 28'h0000007, '0, 128'h1234, "t4_read_07", 1'b0);
        access(0, 1'b1, 1'b0, 28'h000000B, '0, 128'h0, "t3_read_0b", 1'b0);

        // 5: reset in the third BUSY cycle aborts the write
        @(posedge CLK);
        #1;
        wr[0]    = 1'b1;
        addr[0]  = 28'h0000002;
        wdata[0] = '1;
        repeat (3) begin
            @(posedge CLK);
            #1;
        end
        check("t5_busy_before_reset", 128'(busy[0]), 128'(1));
        RESET = 1'b0;
        #1;
        check("t5_busy_after_reset", 128'(busy[0]), 128'(0));
        check("t5_readdata_after_reset", rdata[0], 128'(0));
        wr[0]        = 1'b0;
        last_read[0] = '0;
        last_read[1] = '0;
        repeat (2) @(posedge CLK);
        #1 RESET = 1'b1;
        access(0, 1'b1, 1'b0, 28'h0000002, '0, 128'h0, "t5_read_02", 1'b0);

        // 6: aliasing at LATENCY=1
        access(1, 1'b0, 1'b1, 28'h0000041, 128'hCAFE, '0, "t6_write_41", 1'b0);
        access(1, 1'b1, 1'b0, 28'h0000001, '0, 128'hCAFE, "t6_read_01", 1'b0);
        access(1, 1'b1, 1'b0, 28'h0000041, '0, 128'hCAFE, "t6_read_41", 1'b0);

        repeat (3) @(posedge CLK);
        check("scoreboard_drained", 128'(sb_q.size()), 128'(0));
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
